rede_io_bridge: RTL

Parametrised streaming bridge between the `rede` network's sample-request / output-enable interface and valid/ready streams. The network's `req_in` code pops the next input sample and its `out_en` code pushes a result. An input FIFO feeds the network's `in` port and an output FIFO captures `io_out`. The bridge replaces file-driven stimulus and capture with synthesizable buffering that supports back-pressure, underrun/overrun detection and sample counting.

---
 rtl/rede_io_bridge.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rede_io_bridge.sv
// rede_io_bridge
//   Streaming bridge between the rede network's request / output-enable codes
//   and valid/ready streams. An input FIFO feeds the network `in` port (popped
//   by REQ_CODE on net_req); an output FIFO captures io_out (pushed by OUT_CODE
//   on net_out_en). Sticky underrun/overrun flags and a result counter are kept.
// Ports
//   clk, rst (async, active low), clr (sync clear)
//   s_valid/s_ready/s_data       : upstream sample stream
//   net_in, net_req              : network input port and its request code
//   net_out, net_out_en          : network result and its enable code
//   m_valid/m_ready/m_data       : downstream result stream
//   in_level, out_level          : FIFO occupancies
//   underrun, overrun, out_total : sticky flags and accepted-result count
module rede_io_bridge #(
  parameter int unsigned DW            = 31,
  parameter int unsigned CODE_W        = 4,
  parameter int unsigned REQ_CODE      = 1,
  parameter int unsigned OUT_CODE      = 1,
  parameter int unsigned IN_DEPTH      = 16,
  parameter int unsigned OUT_DEPTH     = 16,
  parameter bit          UNDERRUN_ZERO = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DW-1:0]                 s_data,
  output logic [DW-1:0]                 net_in,
  input  logic [CODE_W-1:0]             net_req,
  input  logic [DW-1:0]                 net_out,
  input  logic [CODE_W-1:0]             net_out_en,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DW-1:0]                 m_data,
  output logic [$clog2(IN_DEPTH):0]     in_level,
  output logic [$clog2(OUT_DEPTH):0]    out_level,
  output logic                          underrun,
  output logic                          overrun,
  output logic [31:0]                   out_total
);

  localparam int unsigned IAW = $clog2(IN_DEPTH);
  localparam int unsigned OAW = $clog2(OUT_DEPTH);
  localparam logic [CODE_W-1:0] REQ_C = CODE_W'(REQ_CODE);
  localparam logic [CODE_W-1:0] OUT_C = CODE_W'(OUT_CODE);

  // Pointers carry one extra wrap bit above the address bits.
  logic [IAW:0]    in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [OAW:0]    out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [DW-1:0]   hold_q, hold_d;
  logic            underrun_q, underrun_d, overrun_q, overrun_d;
  logic [31:0]     total_q, total_d;

  logic [DW-1:0]   in_mem_q  [IN_DEPTH];
  logic [DW-1:0]   out_mem_q [OUT_DEPTH];

  logic in_empty, in_full, out_empty, out_full;
  logic req_hit, en_hit;
  logic in_push, in_pop, out_push, out_pop;
  logic [DW-1:0] in_head;

  assign in_empty  = (in_wr_q == in_rd_q);
  assign in_full   = (in_wr_q[IAW-1:0] == in_rd_q[IAW-1:0]) && (in_wr_q[IAW] != in_rd_q[IAW]);
  assign out_empty = (out_wr_q == out_rd_q);
  assign out_full  = (out_wr_q[OAW-1:0] == out_rd_q[OAW-1:0]) && (out_wr_q[OAW] != out_rd_q[OAW]);

  assign req_hit = (net_req == REQ_C);
  assign en_hit  = (net_out_en == OUT_C);

  assign s_ready  = !in_full;
  assign m_valid  = !out_empty;
  assign in_push  = s_valid && s_ready;
  assign in_pop   = req_hit && !in_empty;
  assign out_pop  = m_valid && m_ready;
  // A full output FIFO can still accept when its head leaves in the same cycle.
  assign out_push = en_hit && (!out_full || out_pop);

  assign in_head   = in_mem_q[in_rd_q[IAW-1:0]];
  assign m_data    = out_mem_q[out_rd_q[OAW-1:0]];
  assign in_level  = in_wr_q - in_rd_q;
  assign out_level = out_wr_q - out_rd_q;
  assign underrun  = underrun_q;
  assign overrun   = overrun_q;
  assign out_total = total_q;

  always_comb begin
    if (!in_empty)          net_in = in_head;
    else if (UNDERRUN_ZERO) net_in = '0;
    else                    net_in = hold_q;
  end

  always_comb begin
    in_wr_d    = in_wr_q;
    in_rd_d    = in_rd_q;
    out_wr_d   = out_wr_q;
    out_rd_d   = out_rd_q;
    hold_d     = hold_q;
    underrun_d = underrun_q;
    overrun_d  = overrun_q;
    total_d    = total_q;
    if (clr) begin
      in_wr_d    = '0;
      in_rd_d    = '0;
      out_wr_d   = '0;
      out_rd_d   = '0;
      hold_d     = '0;
      underrun_d = 1'b0;
      overrun_d  = 1'b0;
      total_d    = '0;
    end else begin
      if (in_push) in_wr_d = in_wr_q + 1'b1;
      if (in_pop) begin
        in_rd_d = in_rd_q + 1'b1;
        hold_d  = in_head;
      end
      if (req_hit && in_empty) underrun_d = 1'b1;
      if (out_pop) out_rd_d = out_rd_q + 1'b1;
      if (out_push) begin
        out_wr_d = out_wr_q + 1'b1;
        total_d  = total_q + 32'd1;
      end
      if (en_hit && !out_push) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_wr_q    <= '0;
      in_rd_q    <= '0;
      out_wr_q   <= '0;
      out_rd_q   <= '0;
      hold_q     <= '0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
      total_q    <= '0;
    end else begin
      in_wr_q    <= in_wr_d;
      in_rd_q    <= in_rd_d;
      out_wr_q   <= out_wr_d;
      out_rd_q   <= out_rd_d;
      hold_q     <= hold_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
      total_q    <= total_d;
    end
  end

  // Storage arrays carry no reset; contents beyond the pointers are don't-care.
  always_ff @(posedge clk) begin
    if (in_push && !clr)  in_mem_q[in_wr_q[IAW-1:0]]   <= s_data;
    if (out_push && !clr) out_mem_q[out_wr_q[OAW-1:0]] <= net_out;
  end

endmodule
